// File: rtl/inst_mem_loadable.sv
// inst_mem_loadable: instruction memory filled by a streamed program load,
// then read by single-cycle-latency fetches with range/alignment checking.
module inst_mem_loadable #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_ready,
   output logic              inst_valid,
   output logic [DATA_W-1:0] inst,
   output logic              addr_err,
   output logic [ADDR_W:0]   word_cnt,
   output logic              load_ovf
);
   localparam int DEPTH = 2**ADDR_W;
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   state_t            state_q, state_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
   logic              load_ovf_q, load_ovf_d;
   logic              inst_valid_q, inst_valid_d;
   logic              addr_err_q, addr_err_d;
   logic [DATA_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] idx;
   logic              wr_en, accept, bad;
   assign fetch_ready = (state_q == RUN) && !load_start;
   assign accept      = fetch_req && fetch_ready;
   assign idx         = fetch_addr[ADDR_W+1:2];
   // word_cnt MSB set means the memory is full (count saturates at DEPTH)
   assign wr_en = (state_q == LOAD) && load_valid && !load_start && !word_cnt_q[ADDR_W];
   assign bad   = (|fetch_addr[1:0]) || (|(fetch_addr >> (ADDR_W+2))) || ({1'b0, idx} >= word_cnt_q);
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      load_ovf_d = load_ovf_q;
      if (load_start) begin
         state_d    = LOAD;
         word_cnt_d = '0;
         load_ovf_d = 1'b0;
      end else if (state_q == LOAD && load_valid) begin
         if (wr_en) word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
         else load_ovf_d = 1'b1;
         if (load_last) state_d = RUN;
      end
      inst_valid_d = accept;
      inst_d       = accept ? (bad ? '0 : mem[idx]) : inst_q;
      addr_err_d   = accept ? bad : addr_err_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         word_cnt_q   <= '0;
         load_ovf_q   <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_q       <= '0;
         addr_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_cnt_q   <= word_cnt_d;
         load_ovf_q   <= load_ovf_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         addr_err_q   <= addr_err_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_en) mem[word_cnt_q[ADDR_W-1:0]] <= load_data;
   end
   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;
   assign addr_err   = addr_err_q;
   assign word_cnt   = word_cnt_q;
   assign load_ovf   = load_ovf_q;
endmodule

// File: doc/inst_mem_loadable.md
INST_MEM_LOADABLE -- requirements
Module: inst_mem_loadable

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning word-index width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous, active-low reset.
REQ-005 SHALL have port load_start, input, 1, meaning a pulse that begins a program load.
REQ-006 SHALL have port load_valid, input, 1, meaning load_data holds a word to write.
REQ-007 SHALL have port load_data, input, DATA_W, meaning the program word.
REQ-008 SHALL have port load_last, input, 1, meaning, with load_valid, that this is the final load word.
REQ-009 SHALL have port fetch_req, input, 1, meaning a fetch request.
REQ-010 SHALL have port fetch_addr, input, 32, meaning the byte address of the fetch.
REQ-011 SHALL have port fetch_ready, output, 1, meaning a fetch is accepted this cycle.
REQ-012 SHALL have port inst_valid, output, 1, meaning inst and addr_err are valid.
REQ-013 SHALL have port inst, output, DATA_W, meaning the fetched instruction.
REQ-014 SHALL have port addr_err, output, 1, meaning the fetch was misaligned, out of range or unloaded.
REQ-015 SHALL have port word_cnt, output, ADDR_W+1, meaning the number of words loaded.
REQ-016 SHALL have port load_ovf, output, 1, meaning sticky overflow: a write was attempted past DEPTH.

Function
REQ-017 SHALL implement the states IDLE, LOAD and RUN.
REQ-018 SHALL go from any state to LOAD when load_start=1, and SHALL clear word_cnt and load_ovf in that cycle.
REQ-019 SHALL, in LOAD with load_valid=1, write load_data to mem[word_cnt] and increment word_cnt when word_cnt<DEPTH; otherwise it SHALL drop the word and set load_ovf.
REQ-020 SHALL go from LOAD to RUN when load_valid=1 and load_last=1, including that word's write.
REQ-021 SHALL give load_start priority over load_valid in the same cycle; that load_valid is ignored.
REQ-022 SHALL ignore load_valid in IDLE and RUN.
REQ-023 SHALL drive fetch_ready=1 only in RUN while load_start=0.
REQ-024 SHALL accept a fetch when fetch_req=1 and fetch_ready=1, and SHALL assert inst_valid exactly one cycle later for one cycle (latency 1).
REQ-025 SHALL use fetch_addr[ADDR_W+1:2] as the word index.
REQ-026 SHALL set addr_err=1 and inst=0 when fetch_addr[1:0]!=0, when any bit of fetch_addr[31:ADDR_W+2] is set, or when index>=word_cnt.
REQ-027 SHALL otherwise return inst = mem[index] with addr_err=0.
REQ-028 SHALL support back-to-back fetches: one accepted per cycle and one result per cycle, in order.
REQ-029 SHALL, for a fetch accepted in the cycle before a load_start, still deliver its result, using the contents and word_cnt from the acceptance cycle.
REQ-030 SHALL hold inst and addr_err at their last values while inst_valid=0.
REQ-031 SHALL keep word_cnt saturated at DEPTH.

Reset
REQ-032 SHALL, on rst_n=0 and regardless of clk, set state=IDLE, fetch_ready=0, inst_valid=0, inst=0, addr_err=0, word_cnt=0 and load_ovf=0.
REQ-033 SHALL leave memory contents undefined after reset; they are unreachable because word_cnt=0.
REQ-034 SHALL resume on the first clk edge after rst_n rises.
REQ-035 SHALL, if reset asserts mid-load or mid-fetch, abort the operation and drop any pending inst_valid.

Verification
REQ-036 SHALL cover load and fetch: load 3 words 0x34014321, 0x34025678, 0xAC040004 (last on the third), then fetch 0x0, 0x4, 0x8 back-to-back -> inst_valid 3 consecutive cycles, same words in order, addr_err=0, word_cnt=3.
REQ-037 SHALL cover fetch errors: after the 3-word load, fetch 0xC, 0x2 and 0x80 (DEPTH=32) -> inst=0 and addr_err=1 for each.
REQ-038 SHALL cover overflow: load 33 words with DEPTH=32 -> word_cnt=32, load_ovf=1, fetch 0x7C returns word 31; a new load_start -> load_ovf=0, word_cnt=0.
REQ-039 SHALL cover reload mid-run: fetch 0x4 accepted, load_start next cycle -> inst_valid with the old word, fetch_ready=0 until load_last.
REQ-040 SHALL cover reset: rst_n low mid-load after 2 words -> all outputs 0 immediately, state IDLE, fetch_ready=0, fetch_req ignored.
REQ-041 SHALL cover IDLE fetch: fetch_req=1 in IDLE -> fetch_ready=0 and no inst_valid.
